// File: rtl/intersection_pkg.sv
// Shared types for the intersection controller: phase encodings, light one-hots, phase durations.
// PED_WALK_EN adds the pedestrian all-red phase and widens the state register to 3 bits.
package intersection_pkg;

`ifdef PED_WALK_EN
  typedef enum logic [2:0] {
    MG_SR = 3'b000,
    MY_SR = 3'b010,
    MR_SG = 3'b011,
    MR_SY = 3'b001,
    PED   = 3'b100
  } state_t;
`else
  typedef enum logic [1:0] {
    MG_SR = 2'b00,
    MY_SR = 2'b10,
    MR_SG = 2'b11,
    MR_SY = 2'b01
  } state_t;
`endif

  // Light vectors are {red, yellow, green}
  localparam logic [2:0] LIGHT_RED    = 3'b100;
  localparam logic [2:0] LIGHT_YELLOW = 3'b010;
  localparam logic [2:0] LIGHT_GREEN  = 3'b001;

  function automatic int unsigned phase_time(state_t s, int unsigned green_t,
                                             int unsigned yellow_t, int unsigned walk_t);
    case (s)
      MG_SR, MR_SG: return green_t;
      MY_SR, MR_SY: return yellow_t;
      default:      return walk_t;
    endcase
  endfunction

endpackage

// File: rtl/intersection_controller_phase_timer.sv
// Per-phase down-counter: loads on phase entry, otherwise decrements and saturates at zero.
module phase_timer #(
  parameter int unsigned           CNT_W   = 4,
  parameter logic [CNT_W-1:0]      RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             time_out
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load)
      cnt_d = load_val;
    else if (cnt_q != '0)
      cnt_d = cnt_q - CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= RST_VAL;
    else     cnt_q <= cnt_d;
  end

  assign time_out = (cnt_q == '0);

endmodule

// File: rtl/intersection_controller.sv
// Two-road intersection sequencer: phase FSM, pedestrian request latch and Moore light decode.
// Optional pedestrian walk phase is enabled by defining PED_WALK_EN.
module intersection_controller
  import intersection_pkg::*;
#(
  parameter int unsigned GREEN_TIME  = 10,
  parameter int unsigned YELLOW_TIME = 3,
  parameter int unsigned WALK_TIME   = 8,
  parameter int unsigned CNT_W       = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       side_car,
  input  logic       ped_req,
  output logic [2:0] phase,
  output logic [2:0] main_light,
  output logic [2:0] side_light,
  output logic       walk,
  output logic       ped_pending,
  output logic       phase_end
);

  state_t           state_q, state_d;
  logic             take;
  logic             time_out;
  logic [CNT_W-1:0] load_val;
  logic             ped_pending_q;

  phase_timer #(
    .CNT_W   (CNT_W),
    .RST_VAL (CNT_W'(GREEN_TIME - 1))
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (take),
    .load_val (load_val),
    .time_out (time_out)
  );

  // Transitions only fire at count zero; main green holds there until demand appears.
  always_comb begin
    state_d = state_q;
    take    = 1'b0;
    if (time_out) begin
      case (state_q)
        MG_SR: if (side_car || ped_pending_q) begin
          state_d = MY_SR;
          take    = 1'b1;
        end
        MY_SR: begin
          state_d = MR_SG;
          take    = 1'b1;
        end
        MR_SG: begin
          state_d = MR_SY;
          take    = 1'b1;
        end
        MR_SY: begin
`ifdef PED_WALK_EN
          state_d = ped_pending_q ? PED : MG_SR;
`else
          state_d = MG_SR;
`endif
          take    = 1'b1;
        end
        default: begin
          state_d = MG_SR;
          take    = 1'b1;
        end
      endcase
    end
  end

  assign load_val = CNT_W'(phase_time(state_d, GREEN_TIME, YELLOW_TIME, WALK_TIME) - 1);

  always_ff @(posedge clk) begin
    if (rst) state_q <= MG_SR;
    else     state_q <= state_d;
  end

`ifdef PED_WALK_EN
  logic ped_pending_d;

  // A request arriving on the PED-entry cycle wins over the clear.
  always_comb begin
    ped_pending_d = ped_pending_q;
    if (take && state_d == PED) ped_pending_d = 1'b0;
    if (ped_req)                ped_pending_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) ped_pending_q <= 1'b0;
    else     ped_pending_q <= ped_pending_d;
  end

  assign walk = (state_q == PED);
`else
  logic unused_ped_req;
  assign unused_ped_req = ped_req;
  assign ped_pending_q  = 1'b0;
  assign walk           = 1'b0;
`endif

  always_comb begin
    main_light = LIGHT_RED;
    side_light = LIGHT_RED;
    case (state_q)
      MG_SR: begin
        main_light = LIGHT_GREEN;
        side_light = LIGHT_RED;
      end
      MY_SR: begin
        main_light = LIGHT_YELLOW;
        side_light = LIGHT_RED;
      end
      MR_SG: begin
        main_light = LIGHT_RED;
        side_light = LIGHT_GREEN;
      end
      MR_SY: begin
        main_light = LIGHT_RED;
        side_light = LIGHT_YELLOW;
      end
      default: begin
        main_light = LIGHT_RED;
        side_light = LIGHT_RED;
      end
    endcase
  end

  assign phase       = 3'(state_q);
  assign ped_pending = ped_pending_q;
  assign phase_end   = take;

endmodule

// File: tb/tb_intersection_controller.sv
// Directed bench for intersection_controller with hand-computed phase timings (default parameters).
module tb_intersection_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       side_car = 1'b0;
  logic       ped_req = 1'b0;
  logic [2:0] phase;
  logic [2:0] main_light;
  logic [2:0] side_light;
  logic       walk;
  logic       ped_pending;
  logic       phase_end;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  localparam logic [2:0] P_MG = 3'b000;
  localparam logic [2:0] P_MY = 3'b010;
  localparam logic [2:0] P_RG = 3'b011;
  localparam logic [2:0] P_RY = 3'b001;
  localparam logic [2:0] P_PD = 3'b100;

  intersection_controller dut (
    .clk         (clk),
    .rst         (rst),
    .side_car    (side_car),
    .ped_req     (ped_req),
    .phase       (phase),
    .main_light  (main_light),
    .side_light  (side_light),
    .walk        (walk),
    .ped_pending (ped_pending),
    .phase_end   (phase_end)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s @cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc = 0;
  endtask

  task automatic run_to(input int c);
    while (cyc < c) tick();
  endtask

  // Expected phase during a round with continuous side traffic and no pedestrian.
  function automatic logic [2:0] round_phase(input int c);
    if (c < 10) return P_MG;
    if (c < 13) return P_MY;
    if (c < 23) return P_RG;
    if (c < 26) return P_RY;
    return P_MG;
  endfunction

  initial begin
    // Reset state and idle hold
    do_reset();
    chk("rst_phase", phase, P_MG);
    chk("rst_main", main_light, 3'b001);
    chk("rst_side", side_light, 3'b100);
    chk("rst_walk", walk, 1'b0);
    chk("rst_pend", ped_pending, 1'b0);
    chk("rst_pend_end", phase_end, 1'b0);
    for (int i = 0; i < 50; i++) begin
      tick();
      chk("idle_phase", phase, P_MG);
      chk("idle_end", phase_end, 1'b0);
      chk("idle_lights", {main_light, side_light}, 6'b001_100);
    end

    // Continuous side traffic from reset
    side_car = 1'b1;
    do_reset();
    for (int i = 0; i < 30; i++) begin
      chk("round_phase", phase, round_phase(cyc));
      chk("round_end", phase_end, (cyc == 9 || cyc == 12 || cyc == 22 || cyc == 25) ? 1'b1 : 1'b0);
      if (cyc == 10) chk("my_lights", {main_light, side_light}, 6'b010_100);
      if (cyc == 13) chk("rg_lights", {main_light, side_light}, 6'b100_001);
      if (cyc == 23) chk("ry_lights", {main_light, side_light}, 6'b100_010);
      if (cyc == 26) chk("mg_lights", {main_light, side_light}, 6'b001_100);
      tick();
    end

    // Late side demand: MG holds at count 0, then leaves on the next edge
    side_car = 1'b0;
    do_reset();
    run_to(30);
    chk("late_hold", phase, P_MG);
    chk("late_noend", phase_end, 1'b0);
    side_car = 1'b1;
    #1;
    chk("late_end", phase_end, 1'b1);
    tick();
    chk("late_my", phase, P_MY);
    side_car = 1'b0;

`ifdef PED_WALK_EN
    // Pedestrian round with no side traffic
    do_reset();
    run_to(4);
    ped_req = 1'b1;
    tick();
    ped_req = 1'b0;
    chk("ped_latch", ped_pending, 1'b1);
    run_to(9);
    chk("ped_mg_end", phase_end, 1'b1);
    tick();
    chk("ped_my", phase, P_MY);
    run_to(13);
    chk("ped_rg", phase, P_RG);
    run_to(23);
    chk("ped_ry", phase, P_RY);
    run_to(25);
    chk("ped_ry_end", phase_end, 1'b1);
    tick();
    chk("ped_phase", phase, P_PD);
    chk("ped_walk", walk, 1'b1);
    chk("ped_allred", {main_light, side_light}, 6'b100_100);
    chk("ped_clear", ped_pending, 1'b0);
    run_to(28);
    ped_req = 1'b1;
    tick();
    ped_req = 1'b0;
    chk("ped_rearm", ped_pending, 1'b1);
    run_to(33);
    chk("ped_last", phase, P_PD);
    chk("ped_last_end", phase_end, 1'b1);
    tick();
    chk("ped_back_mg", phase, P_MG);
    chk("ped_back_walk", walk, 1'b0);
    chk("ped_kept", ped_pending, 1'b1);
    run_to(43);
    chk("ped2_end", phase_end, 1'b1);
    tick();
    chk("ped2_my", phase, P_MY);

    // Reset during MR_SG with a pending request
    side_car = 1'b1;
    do_reset();
    run_to(2);
    ped_req = 1'b1;
    tick();
    ped_req = 1'b0;
    run_to(15);
    chk("mid_rg", phase, P_RG);
    chk("mid_pend", ped_pending, 1'b1);
    do_reset();
    chk("mid_rst_phase", phase, P_MG);
    chk("mid_rst_pend", ped_pending, 1'b0);
    run_to(8);
    chk("mid_cnt8", phase_end, 1'b0);
    tick();
    chk("mid_cnt9", phase_end, 1'b1);
    side_car = 1'b0;
`else
    // Reset during MR_SG
    side_car = 1'b1;
    do_reset();
    run_to(15);
    chk("mid_rg", phase, P_RG);
    do_reset();
    chk("mid_rst_phase", phase, P_MG);
    chk("mid_rst_pend", ped_pending, 1'b0);
    run_to(8);
    chk("mid_cnt8", phase_end, 1'b0);
    tick();
    chk("mid_cnt9", phase_end, 1'b1);
    side_car = 1'b0;

    // Pedestrian button has no effect without the walk feature
    do_reset();
    run_to(4);
    ped_req = 1'b1;
    tick();
    ped_req = 1'b0;
    for (int i = 0; i < 30; i++) begin
      chk("noped_phase", phase, P_MG);
      chk("noped_walk", walk, 1'b0);
      chk("noped_pend", ped_pending, 1'b0);
      tick();
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
